// File: rtl/instr_fetch_stage.sv
// ============================================================================
// Module   : instr_fetch_stage
// Brief    : Fetches the instruction image in order and delivers it to decode through a small FIFO.
//            Optional macro HALT_DETECT_EN ends the run early on a HALT opcode.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module instr_fetch_stage #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_INSTR  = 1024
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              start,
   input  logic              flush,
   input  logic              opr_1,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              fd_valid,
   input  logic              fd_ready,
   output logic [DATA_W-1:0] fd_instr,
   output logic [ADDR_W-1:0] fd_pc,
   output logic              busy,
   output logic              fetch_done,
   output logic [ADDR_W:0]   fetch_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [ADDR_W:0]  NUM_CNT   = (ADDR_W+1)'(NUM_INSTR);
   localparam logic [ADDR_W:0]  LAST_CNT  = (ADDR_W+1)'(NUM_INSTR - 1);
   localparam logic [PTR_W+1:0] DEPTH_OCC = (PTR_W+2)'(FIFO_DEPTH);

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   logic              cap_valid;
   logic [ADDR_W-1:0] cap_addr;

   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    fifo_count;

   logic              push;
   logic              pop;
   logic [PTR_W+1:0]  occupancy;
   logic              halt_seen;
   logic              issue;
   logic              drain_done;

   // Reads in flight are the strobe cycle (mem_rd_en) and the data-return cycle (cap_valid);
   // both are reserved against FIFO space so a push can never find the FIFO full.
   assign occupancy = {1'b0, fifo_count}
                    + {{(PTR_W+1){1'b0}}, mem_rd_en}
                    + {{(PTR_W+1){1'b0}}, cap_valid};

   assign push = cap_valid;
   assign pop  = fd_valid & fd_ready;

`ifdef HALT_DETECT_EN
   assign halt_seen = cap_valid && (mem_rdata[31:26] == 6'h11);
`else
   assign halt_seen = 1'b0;
`endif

   assign issue = (state == ST_FETCH) && opr_1 && (occupancy < DEPTH_OCC)
                  && (fetch_count < NUM_CNT) && !halt_seen;

   assign drain_done = (state == ST_DRAIN) && (fifo_count == '0)
                       && !mem_rd_en && !cap_valid;

   assign busy     = (state == ST_FETCH) || (state == ST_DRAIN);
   assign fd_valid = (fifo_count != '0);
   assign fd_instr = fifo_data[rd_ptr];
   assign fd_pc    = fifo_pc[rd_ptr];

   always_ff @(posedge clk) begin
      if (rstb || flush) begin
         state       <= ST_IDLE;
         pc          <= '0;
         fetch_count <= '0;
         mem_rd_en   <= 1'b0;
         mem_addr    <= '0;
         cap_valid   <= 1'b0;
         cap_addr    <= '0;
         fetch_done  <= 1'b0;
      end else begin
         fetch_done <= 1'b0;
         mem_rd_en  <= issue;
         cap_valid  <= mem_rd_en;
         cap_addr   <= mem_addr;

         if (issue) begin
            mem_addr    <= pc;
            pc          <= pc + ADDR_W'(1);
            fetch_count <= fetch_count + (ADDR_W+1)'(1);
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state       <= ST_FETCH;
                  pc          <= '0;
                  fetch_count <= '0;
               end
            end
            ST_FETCH: begin
               if ((issue && (fetch_count == LAST_CNT)) || halt_seen) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  state      <= ST_IDLE;
                  fetch_done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Storage is cleared too, so the head reads as zero straight after reset or flush.
   always_ff @(posedge clk) begin
      if (rstb || flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_pc[i]   <= '0;
         end
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]   <= cap_addr;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
            2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
// ============================================================================
// Module   : tb_instr_fetch_stage
// Brief    : Self-checking bench for instr_fetch_stage (cycle vector table plus run-level sequences).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch_stage;

   logic        clk = 1'b0;
   logic        rstb = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic        opr_1 = 1'b0;
   logic        fd_ready = 1'b0;
   logic        mem_rd_en;
   logic [9:0]  mem_addr;
   logic [31:0] mem_rdata = 32'h0;
   logic        fd_valid;
   logic [31:0] fd_instr;
   logic [9:0]  fd_pc;
   logic        busy;
   logic        fetch_done;
   logic [10:0] fetch_count;

   instr_fetch_stage dut (
      .clk(clk), .rstb(rstb), .start(start), .flush(flush), .opr_1(opr_1),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .fd_valid(fd_valid), .fd_ready(fd_ready), .fd_instr(fd_instr), .fd_pc(fd_pc),
      .busy(busy), .fetch_done(fetch_done), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   logic halt_mode = 1'b0;

   function automatic logic [31:0] image(input int a);
      if (halt_mode && a == 5) return 32'h4400_0000;
      return {8'hA5, 4'h0, a[9:0], a[9:0]};
   endfunction

   // Synchronous memory: data appears the cycle after the strobe, junk otherwise.
   int cyc = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd_en) mem_rdata <= image(int'(mem_addr));
      else           mem_rdata <= 32'hBAD0_0000 | 32'(cyc[15:0]);
   end

   // Scoreboard: every accepted word must be the next address in order.
   int   sb_exp = 0, sb_n = 0, sb_bad = 0, done_cnt = 0, iss_cnt = 0, bad_iss = 0;
   logic opr_q = 1'b0;
   always @(posedge clk) opr_q <= opr_1;
   always @(negedge clk) begin
      if (fd_valid && fd_ready) begin
         if (fd_pc !== 10'(sb_exp) || fd_instr !== image(sb_exp)) sb_bad++;
         sb_exp++;
         sb_n++;
      end
      if (fetch_done) done_cnt++;
      if (mem_rd_en) begin
         iss_cnt++;
         if (!opr_q) bad_iss++;
      end
   end

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_clear();
      sb_exp = 0; sb_n = 0; sb_bad = 0; iss_cnt = 0; bad_iss = 0;
   endtask

   task automatic do_reset();
      rstb = 1'b1; start = 1'b0; flush = 1'b0;
      step(); step();
      rstb = 1'b0;
      sb_clear();
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0 = done_cnt;
      int i  = 0;
      while (done_cnt == d0 && i < budget) begin
         step();
         i++;
      end
      chk({name, "_done_in_time"}, 96'(done_cnt != d0), 96'd1);
      step(); step(); step();
   endtask

   task automatic wait_count(input string name, input int target, input int budget);
      int i = 0;
      while (fetch_count != 11'(target) && i < budget) begin
         step();
         i++;
      end
      chk(name, 96'(fetch_count), 96'(target));
   endtask

   typedef struct {
      logic        rstb, start, flush, opr, rdy;
      logic        rd_en;
      logic [9:0]  addr;
      logic        valid;
      logic [9:0]  pc;
      logic [31:0] instr;
      logic        busy, done;
      logic [10:0] fc;
   } vec_t;

   function automatic vec_t mk(input logic r, s, f, o, y, rd, input int a, input logic v,
                               input int p, input logic [31:0] ins, input logic b,
                               input int fc);
      vec_t t;
      t.rstb = r; t.start = s; t.flush = f; t.opr = o; t.rdy = y;
      t.rd_en = rd; t.addr = 10'(a); t.valid = v; t.pc = 10'(p); t.instr = ins;
      t.busy = b; t.done = 1'b0; t.fc = 11'(fc);
      return t;
   endfunction

   function automatic logic [95:0] outs();
      return 96'({mem_rd_en, mem_addr, fd_valid, fd_pc, fd_instr, busy, fetch_done, fetch_count});
   endfunction

   vec_t tv[18];

   initial begin
      int d0;
      int stall_iss;

      //          rst st fl op rdy | rd addr val pc instr     busy fc
      tv[0]  = mk(1, 0, 0, 0, 0,     0, 0,   0,  0, 32'h0,     0,  0);
      tv[1]  = mk(1, 1, 0, 0, 0,     0, 0,   0,  0, 32'h0,     0,  0);
      tv[2]  = mk(0, 0, 0, 1, 0,     0, 0,   0,  0, 32'h0,     0,  0);
      tv[3]  = mk(0, 1, 0, 1, 0,     0, 0,   0,  0, 32'h0,     1,  0);
      tv[4]  = mk(0, 0, 0, 1, 0,     1, 0,   0,  0, 32'h0,     1,  1);
      tv[5]  = mk(0, 0, 0, 1, 0,     1, 1,   0,  0, 32'h0,     1,  2);
      tv[6]  = mk(0, 0, 0, 1, 0,     1, 2,   1,  0, image(0),  1,  3);
      tv[7]  = mk(0, 0, 0, 1, 0,     1, 3,   1,  0, image(0),  1,  4);
      tv[8]  = mk(0, 0, 0, 1, 0,     0, 3,   1,  0, image(0),  1,  4);
      tv[9]  = mk(0, 0, 0, 1, 0,     0, 3,   1,  0, image(0),  1,  4);
      tv[10] = mk(0, 0, 0, 1, 0,     0, 3,   1,  0, image(0),  1,  4);
      tv[11] = mk(0, 0, 0, 1, 1,     0, 3,   1,  1, image(1),  1,  4);
      tv[12] = mk(0, 0, 0, 1, 1,     1, 4,   1,  2, image(2),  1,  5);
      tv[13] = mk(0, 0, 0, 0, 0,     0, 4,   1,  2, image(2),  1,  5);
      tv[14] = mk(0, 1, 1, 0, 0,     0, 0,   0,  0, 32'h0,     0,  0);
      tv[15] = mk(0, 0, 0, 1, 1,     0, 0,   0,  0, 32'h0,     0,  0);
      tv[16] = mk(0, 1, 0, 1, 1,     0, 0,   0,  0, 32'h0,     1,  0);
      tv[17] = mk(0, 0, 0, 1, 1,     1, 0,   0,  0, 32'h0,     1,  1);

      for (int i = 0; i < 18; i++) begin
         rstb = tv[i].rstb; start = tv[i].start; flush = tv[i].flush;
         opr_1 = tv[i].opr; fd_ready = tv[i].rdy;
         step();
         chk($sformatf("vec%0d", i), outs(),
             96'({tv[i].rd_en, tv[i].addr, tv[i].valid, tv[i].pc, tv[i].instr,
                  tv[i].busy, tv[i].done, tv[i].fc}));
      end

      // Full run: latency, ordering, single done pulse, final count.
      do_reset();
      opr_1 = 1'b1; fd_ready = 1'b1; d0 = done_cnt;
      start = 1'b1; step(); start = 1'b0;
      step(); chk("lat_edge1_valid", 96'(fd_valid), 96'd0);
      step(); chk("lat_edge2_valid", 96'(fd_valid), 96'd0);
      step(); chk("lat_edge3_valid", 96'(fd_valid), 96'd1);
      wait_done("full", 2000);
      chk("full_words", 96'(sb_n), 96'd1024);
      chk("full_order_errs", 96'(sb_bad), 96'd0);
      chk("full_issues", 96'(iss_cnt), 96'd1024);
      chk("full_done_pulses", 96'(done_cnt - d0), 96'd1);
      chk("full_fetch_count", 96'(fetch_count), 96'd1024);
      chk("full_idle", 96'({busy, fd_valid}), 96'd0);

      // Decode stall for 20 cycles, plus a start while busy that must be ignored.
      do_reset();
      opr_1 = 1'b1; fd_ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 50; i++) step();
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 50; i++) step();
      fd_ready = 1'b0; stall_iss = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i >= 6 && mem_rd_en) stall_iss++;
      end
      chk("stall_no_issue", 96'(stall_iss), 96'd0);
      chk("stall_head_pc", 96'({fd_valid, fd_pc}), 96'({1'b1, 10'(sb_exp)}));
      fd_ready = 1'b1;
      wait_done("stall", 2000);
      chk("stall_words", 96'(sb_n), 96'd1024);
      chk("stall_order_errs", 96'(sb_bad), 96'd0);

      // opr_1 toggling: issues only follow opr_1=1 edges.
      do_reset();
      fd_ready = 1'b1; opr_1 = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 5000 && done_cnt == d0; i++) begin
         opr_1 = ~opr_1;
         step();
      end
      chk("toggle_done", 96'(done_cnt - d0), 96'd1);
      step(); step();
      chk("toggle_bad_issues", 96'(bad_iss), 96'd0);
      chk("toggle_words", 96'(sb_n), 96'd1024);
      chk("toggle_order_errs", 96'(sb_bad), 96'd0);

      // Flush at fetch_count=37 with three words buffered.
      do_reset();
      opr_1 = 1'b1; fd_ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      wait_count("flush_reach34", 34, 200);
      opr_1 = 1'b0;
      for (int i = 0; i < 5; i++) step();
      fd_ready = 1'b0; opr_1 = 1'b1;
      wait_count("flush_reach37", 37, 20);
      opr_1 = 1'b0;
      step(); step();
      chk("flush_pre_valid", 96'(fd_valid), 96'd1);
      d0 = done_cnt;
      flush = 1'b1; start = 1'b1; step(); flush = 1'b0; start = 1'b0;
      chk("flush_outputs", 96'({fd_valid, busy, mem_rd_en}), 96'd0);
      step(); step(); step();
      chk("flush_stays_idle", 96'({fd_valid, busy}), 96'd0);
      chk("flush_no_done", 96'(done_cnt - d0), 96'd0);
      sb_clear();
      fd_ready = 1'b0; opr_1 = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 10 && !fd_valid; i++) step();
      chk("refetch_first", 96'({fd_valid, fd_pc, fd_instr}), 96'({1'b1, 10'd0, image(0)}));

      // Reset in DRAIN with a simultaneous start.
      do_reset();
      opr_1 = 1'b1; fd_ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      wait_count("drain_reach", 1024, 1200);
      chk("drain_busy", 96'(busy), 96'd1);
      d0 = done_cnt;
      rstb = 1'b1; start = 1'b1; step();
      chk("drain_reset_outs", outs(), 96'd0);
      rstb = 1'b0; start = 1'b0; step(); step();
      chk("drain_start_ignored", 96'({busy, fd_valid}), 96'd0);
      chk("drain_no_done", 96'(done_cnt - d0), 96'd0);

      // HALT word at address 5.
      do_reset();
      halt_mode = 1'b1;
      opr_1 = 1'b1; fd_ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      wait_done("halt", 2000);
`ifdef HALT_DETECT_EN
      chk("halt_words", 96'(sb_n == 6 || sb_n == 7), 96'd1);
`else
      chk("halt_words", 96'(sb_n), 96'd1024);
`endif
      chk("halt_order_errs", 96'(sb_bad), 96'd0);
      halt_mode = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
